// File: rtl/alu_cmd_loader.sv
// alu_cmd_loader: assembles an ALU command from three strobed bytes on an
// 8-bit pin bus (opcode, operand A, operand B) and presents the complete
// command to the ALU stage through a valid/ready handshake. Malformed input
// is flagged by an opcode range check, an inter-byte timeout and overrun
// detection.
//
// Optional feature (macro ALU_CMD_CHAIN_EN): adds result_in. An opcode byte
// with bit 7 set loads operand A from result_in, so the command needs only
// two strobes.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   in_data    byte from the pin bus, captured on the strobe rising edge
//   in_strobe  byte strobe level; only rising edges count
//   out_ready  ALU stage can accept a command
//   result_in  (ALU_CMD_CHAIN_EN only) registered ALU result fed back
//   out_valid  command valid
//   out_opcode ALU opcode
//   out_a      operand A
//   out_b      operand B
//   busy       high whenever the FSM is not in IDLE
//   err        one-cycle error pulse
//   err_code   last error: 0 none, 1 illegal opcode, 2 timeout, 3 overrun
module alu_cmd_loader #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned NUM_OPS        = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_strobe,
    input  logic             out_ready,
`ifdef ALU_CMD_CHAIN_EN
    input  logic [WIDTH-1:0] result_in,
`endif
    output logic             out_valid,
    output logic [3:0]       out_opcode,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_A = 2'd1,
        GET_B = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             strobe_prev;
    logic [CNT_W-1:0] idle_cnt;

    logic             stb_c;
    logic             op_legal_c;
    logic             chain_c;
    logic             counting_c;
    logic             expired_c;
    logic             load_op_c;
    logic             load_a_c;
    logic             load_b_c;
    logic [WIDTH-1:0] a_src_c;
    logic             err_set_c;
    logic [1:0]       err_cause_c;

    // Rising edge of the strobe pin; in_data is taken in this same cycle.
    assign stb_c      = in_strobe & ~strobe_prev;
    assign op_legal_c = (5'(in_data[OP_W-1:0]) < 5'(NUM_OPS));

`ifdef ALU_CMD_CHAIN_EN
    assign chain_c = in_data[7];
`else
    assign chain_c = 1'b0;
`endif

    // Idle counter only runs while waiting for operand bytes; a strobe in
    // the expiry cycle wins over the timeout.
    assign counting_c = ((state == GET_A) || (state == GET_B)) && !stb_c;
    assign expired_c  = counting_c && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, load enables and error decode
    always_comb begin
        state_next  = state;
        load_op_c   = 1'b0;
        load_a_c    = 1'b0;
        load_b_c    = 1'b0;
        a_src_c     = in_data;
        err_set_c   = 1'b0;
        err_cause_c = 2'd0;
        case (state)
            IDLE: begin
                if (stb_c) begin
                    if (op_legal_c) begin
                        load_op_c = 1'b1;
                        if (chain_c) begin
`ifdef ALU_CMD_CHAIN_EN
                            a_src_c = result_in;
`endif
                            load_a_c   = 1'b1;
                            state_next = GET_B;
                        end else begin
                            state_next = GET_A;
                        end
                    end else begin
                        err_set_c   = 1'b1;
                        err_cause_c = ERR_ILLEGAL;
                    end
                end
            end
            GET_A: begin
                if (stb_c) begin
                    load_a_c   = 1'b1;
                    state_next = GET_B;
                end else if (expired_c) begin
                    err_set_c   = 1'b1;
                    err_cause_c = ERR_TIMEOUT;
                    state_next  = IDLE;
                end
            end
            GET_B: begin
                if (stb_c) begin
                    load_b_c   = 1'b1;
                    state_next = ISSUE;
                end else if (expired_c) begin
                    err_set_c   = 1'b1;
                    err_cause_c = ERR_TIMEOUT;
                    state_next  = IDLE;
                end
            end
            ISSUE: begin
                // Byte arriving while a command is held is dropped, even on
                // the handshake cycle.
                if (stb_c) begin
                    err_set_c   = 1'b1;
                    err_cause_c = ERR_OVERRUN;
                end
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath, edge detect, idle counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_prev <= 1'b0;
            idle_cnt    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
            out_opcode  <= 4'd0;
            out_a       <= '0;
            out_b       <= '0;
        end else begin
            strobe_prev <= in_strobe;
            idle_cnt    <= counting_c ? CNT_W'(idle_cnt + 1'b1) : '0;
            out_valid   <= (state_next == ISSUE);
            busy        <= (state_next != IDLE);
            err         <= err_set_c;
            if (err_set_c) begin
                err_code <= err_cause_c;
            end
            if (load_op_c) begin
                out_opcode <= in_data[OP_W-1:0];
            end
            if (load_a_c) begin
                out_a <= a_src_c;
            end
            if (load_b_c) begin
                out_b <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_loader.sv
// Self-checking bench for alu_cmd_loader: directed scenarios plus random
// traffic, compared each cycle against a byte-queue reference model.
module tb_alu_cmd_loader;

    localparam int unsigned WIDTH          = 8;
    localparam int unsigned NUM_OPS        = 12;
    localparam int unsigned TIMEOUT_CYCLES = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_strobe;
    logic             out_ready;
`ifdef ALU_CMD_CHAIN_EN
    logic [WIDTH-1:0] result_in;
`endif
    logic             out_valid;
    logic [3:0]       out_opcode;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             busy;
    logic             err;
    logic [1:0]       err_code;

    int checks   = 0;
    int failures = 0;

    alu_cmd_loader #(
        .WIDTH(WIDTH),
        .NUM_OPS(NUM_OPS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_strobe(in_strobe),
        .out_ready(out_ready),
`ifdef ALU_CMD_CHAIN_EN
        .result_in(result_in),
`endif
        .out_valid(out_valid),
        .out_opcode(out_opcode),
        .out_a(out_a),
        .out_b(out_b),
        .busy(busy),
        .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference model: bytes collected so far, a held command flag and an
    // idle-cycle count since the last accepted byte.
    logic [7:0] mq[$];
    bit         m_pending;
    int         m_idle;
    bit         m_prev;
    logic       m_err;
    logic [1:0] m_code;
    logic [3:0] m_op;
    logic [7:0] m_a;
    logic [7:0] m_b;

    typedef logic [24:0] vec_t;

    function automatic vec_t obs();
        return {out_valid, busy, err, err_code, out_opcode, out_a, out_b};
    endfunction

    function automatic vec_t expv();
        return {m_pending, (m_pending || (mq.size() != 0)), m_err, m_code, m_op, m_a, m_b};
    endfunction

    // Drive one cycle of inputs, clock it, then advance the model.
    task automatic tick(input logic s, input logic [7:0] d, input logic r);
        bit stb;
        in_strobe = s;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
        stb    = s && !m_prev;
        m_prev = s;
        m_err  = 1'b0;
        if (rst) begin
            mq.delete();
            m_pending = 0;
            m_idle    = 0;
            m_prev    = 0;
            m_code    = 2'd0;
            m_op      = 4'd0;
            m_a       = 8'd0;
            m_b       = 8'd0;
        end else if (m_pending) begin
            if (stb) begin
                m_err  = 1'b1;
                m_code = 2'd3;
            end
            if (r) m_pending = 0;
        end else if (stb) begin
            m_idle = 0;
            if (mq.size() == 0) begin
                if (int'(d[3:0]) < NUM_OPS) begin
                    mq.push_back(d);
                    m_op = d[3:0];
`ifdef ALU_CMD_CHAIN_EN
                    if (d[7]) begin
                        mq.push_back(result_in);
                        m_a = result_in;
                    end
`endif
                end else begin
                    m_err  = 1'b1;
                    m_code = 2'd1;
                end
            end else begin
                if (mq.size() == 1) m_a = d;
                else                m_b = d;
                mq.push_back(d);
                if (mq.size() == 3) begin
                    mq.delete();
                    m_pending = 1;
                end
            end
        end else if (mq.size() != 0) begin
            m_idle++;
            if (m_idle >= int'(TIMEOUT_CYCLES)) begin
                mq.delete();
                m_err  = 1'b1;
                m_code = 2'd2;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (obs() !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), 25'd0);
        end
        rst = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_basic();
        logic [7:0] seq [3];
        seq = '{8'h03, 8'h5A, 8'h21};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, seq[i], 1'b1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL basic_model byte=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (i < 2) tick(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if ({out_valid, out_opcode, out_a, out_b} !== {1'b1, 4'd3, 8'h5A, 8'h21}) begin
            failures++;
            $display("FAIL basic_cmd got=%h exp=%h",
                     {out_valid, out_opcode, out_a, out_b}, {1'b1, 4'd3, 8'h5A, 8'h21});
        end
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL basic_done got=%b exp=00", {out_valid, busy});
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] seq [3];
        seq = '{8'h01, 8'h10, 8'h20};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, seq[i], 1'b0);
            tick(1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0);
        checks++;
        if ({out_valid, out_a, out_b} !== {1'b1, 8'h10, 8'h20}) begin
            failures++;
            $display("FAIL bp_hold got=%h exp=%h", {out_valid, out_a, out_b}, {1'b1, 8'h10, 8'h20});
        end
        tick(1'b1, 8'hFF, 1'b0);
        checks++;
        if ({err, err_code, out_valid, out_opcode, out_a, out_b} !== {1'b1, 2'd3, 1'b1, 4'd1, 8'h10, 8'h20}) begin
            failures++;
            $display("FAIL bp_overrun got=%h exp=%h", {err, err_code, out_valid, out_opcode, out_a, out_b},
                     {1'b1, 2'd3, 1'b1, 4'd1, 8'h10, 8'h20});
        end
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if ({err, err_code, out_valid} !== {1'b0, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL bp_err_pulse got=%b exp=0111", {err, err_code, out_valid});
        end
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL bp_complete got=%b exp=00", {out_valid, busy});
        end
    endtask

    task automatic test_illegal();
        logic [7:0] ops [3];
        ops = '{8'h0D, 8'h0C, 8'h0F};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, ops[i], 1'b1);
            checks++;
            if ({err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
                failures++;
                $display("FAIL illegal_op op=%h got=%b exp=1010", ops[i], {err, err_code, busy});
            end
            tick(1'b0, 8'h00, 1'b1);
        end
        // Highest legal opcode runs a normal command afterwards.
        tick(1'b1, 8'h0B, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'hC3, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h3C, 1'b1);
        checks++;
        if ({out_valid, out_opcode, out_a, out_b, err} !== {1'b1, 4'hB, 8'hC3, 8'h3C, 1'b0}) begin
            failures++;
            $display("FAIL illegal_recover got=%h exp=%h", {out_valid, out_opcode, out_a, out_b, err},
                     {1'b1, 4'hB, 8'hC3, 8'h3C, 1'b0});
        end
        tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_timeout();
        tick(1'b1, 8'h02, 1'b1);
        for (int i = 1; i < int'(TIMEOUT_CYCLES); i++) begin
            tick(1'b0, 8'h00, 1'b1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL timeout_wait idle=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if ({busy, err} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_early got=%b exp=10", {busy, err});
        end
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if ({busy, err, err_code} !== {1'b0, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL timeout_fire got=%b exp=0110", {busy, err, err_code});
        end
        tick(1'b0, 8'h00, 1'b1);
        // Strobe on idle cycle 254 saves operand A; strobe on the expiry
        // cycle itself (255) still wins for operand B.
        tick(1'b1, 8'h07, 1'b0);
        for (int i = 1; i < int'(TIMEOUT_CYCLES) - 1; i++) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h33, 1'b0);
        checks++;
        if ({busy, err, out_a} !== {1'b1, 1'b0, 8'h33}) begin
            failures++;
            $display("FAIL timeout_cycle254 got=%h exp=%h", {busy, err, out_a}, {1'b1, 1'b0, 8'h33});
        end
        for (int i = 1; i < int'(TIMEOUT_CYCLES); i++) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h44, 1'b0);
        checks++;
        if ({out_valid, err, out_opcode, out_a, out_b} !== {1'b1, 1'b0, 4'd7, 8'h33, 8'h44}) begin
            failures++;
            $display("FAIL timeout_tie got=%h exp=%h", {out_valid, err, out_opcode, out_a, out_b},
                     {1'b1, 1'b0, 4'd7, 8'h33, 8'h44});
        end
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL timeout_drain got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_held_and_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, 8'h04 + 8'(i * 16), 1'b1);
        checks++;
        if ({busy, out_opcode, err} !== {1'b1, 4'd4, 1'b0}) begin
            failures++;
            $display("FAIL held_one_byte got=%h exp=%h", {busy, out_opcode, err}, {1'b1, 4'd4, 1'b0});
        end
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL held_model got=%h exp=%h", obs(), expv());
        end
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h99, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        tick(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        checks++;
        if (obs() !== 25'd0) begin
            failures++;
            $display("FAIL reset_mid_cmd got=%h exp=%h", obs(), 25'd0);
        end
        tick(1'b1, 8'h06, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'hAB, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'hCD, 1'b1);
        checks++;
        if ({out_valid, out_opcode, out_a, out_b} !== {1'b1, 4'd6, 8'hAB, 8'hCD}) begin
            failures++;
            $display("FAIL reset_fresh_cmd got=%h exp=%h", {out_valid, out_opcode, out_a, out_b},
                     {1'b1, 4'd6, 8'hAB, 8'hCD});
        end
        tick(1'b0, 8'h00, 1'b1);
    endtask

`ifdef ALU_CMD_CHAIN_EN
    task automatic test_chain();
        result_in = 8'h77;
        tick(1'b1, 8'h84, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h05, 1'b1);
        checks++;
        if ({out_valid, out_opcode, out_a, out_b} !== {1'b1, 4'd4, 8'h77, 8'h05}) begin
            failures++;
            $display("FAIL chain_cmd got=%h exp=%h", {out_valid, out_opcode, out_a, out_b},
                     {1'b1, 4'd4, 8'h77, 8'h05});
        end
        tick(1'b0, 8'h00, 1'b1);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
`ifdef ALU_CMD_CHAIN_EN
            result_in = 8'($urandom);
`endif
            tick(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) != 0));
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_strobe = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef ALU_CMD_CHAIN_EN
        result_in = 8'h00;
`endif
        m_prev    = 0;
        m_pending = 0;
        m_idle    = 0;
        m_err     = 1'b0;
        m_code    = 2'd0;
        m_op      = 4'd0;
        m_a       = 8'd0;
        m_b       = 8'd0;
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_timeout();
        test_held_and_reset();
`ifdef ALU_CMD_CHAIN_EN
        test_chain();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
